// File: rtl/id_ex_alu_decode.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_alu_decode
// Purpose  : ID/EX pipeline stage. Decodes a 32-bit MIPS instruction into the
//            ALU operation and the EX operand/control bundle, then registers
//            the bundle. Supports hazard-unit stall/flush and flags
//            unsupported instructions.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_alu_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [2:0]  ex_alu_control,
  output logic [31:0] ex_srcA,
  output logic [31:0] ex_srcB,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_illegal
);

  // ALU operation encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SPEC2 = 6'b011100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign op       = id_instr[31:26];
  assign rt_idx   = id_instr[20:16];
  assign rd_idx   = id_instr[15:11];
  assign funct    = id_instr[5:0];
  assign imm_sext = {{16{id_instr[15]}}, id_instr[15:0]};
  assign imm_zext = {16'b0, id_instr[15:0]};

  // rs index and shamt are not needed: operand A arrives as data and no
  // shift operations are supported.
  logic unused_fields;
  assign unused_fields = ^{id_instr[25:21], id_instr[10:6]};

  // Decoded (next-state) bundle
  logic [2:0]  alu_d;
  logic [31:0] srcB_d;
  logic [4:0]  dest_d;
  logic        rw_raw;
  logic        reg_write_d;
  logic        mem_read_d;
  logic        mem_write_d;
  logic        branch_d;
  logic        illegal_d;

  // Pipeline register state
  logic        valid_q;
  logic [2:0]  alu_q;
  logic [31:0] srcA_q;
  logic [31:0] srcB_q;
  logic [31:0] store_q;
  logic [4:0]  dest_q;
  logic        reg_write_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        branch_q;
  logic        illegal_q;

  // Combinational decode of the ID instruction into the EX bundle
  always_comb begin
    alu_d       = ALU_AND;
    srcB_d      = id_rt_data;
    dest_d      = 5'd0;
    rw_raw      = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    illegal_d   = 1'b0;
    case (op)
      OP_RTYPE: begin
        dest_d = rd_idx;
        rw_raw = 1'b1;
        case (funct)
          6'b100000, 6'b100001: alu_d = ALU_ADD;
          6'b100010, 6'b100011: alu_d = ALU_SUB;
          6'b100100:            alu_d = ALU_AND;
          6'b100101:            alu_d = ALU_OR;
          6'b101010:            alu_d = ALU_SLT;
          default: begin
            illegal_d = 1'b1;
            dest_d    = 5'd0;
            rw_raw    = 1'b0;
          end
        endcase
      end
      OP_SPEC2: begin
        if (funct == 6'b000010) begin
          alu_d  = ALU_MUL;
          dest_d = rd_idx;
          rw_raw = 1'b1;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU: begin
        alu_d  = ALU_ADD;
        srcB_d = imm_sext;
        dest_d = rt_idx;
        rw_raw = 1'b1;
      end
      OP_ANDI: begin
        alu_d  = ALU_AND;
        srcB_d = imm_zext;
        dest_d = rt_idx;
        rw_raw = 1'b1;
      end
      OP_ORI: begin
        alu_d  = ALU_OR;
        srcB_d = imm_zext;
        dest_d = rt_idx;
        rw_raw = 1'b1;
      end
      OP_SLTI: begin
        alu_d  = ALU_SLT;
        srcB_d = imm_sext;
        dest_d = rt_idx;
        rw_raw = 1'b1;
      end
      OP_LW: begin
        alu_d      = ALU_ADD;
        srcB_d     = imm_sext;
        dest_d     = rt_idx;
        rw_raw     = 1'b1;
        mem_read_d = 1'b1;
      end
      OP_SW: begin
        alu_d       = ALU_ADD;
        srcB_d      = imm_sext;
        mem_write_d = 1'b1;
      end
      OP_BEQ: begin
        alu_d    = ALU_SUB;
        branch_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Register $0 is hardwired to zero, so a write to it is dropped here.
  assign reg_write_d = rw_raw & (dest_d != 5'd0);

  // ID/EX register: reset > flush > stall > load; an invalid ID slot loads a bubble
  always_ff @(posedge clk) begin
    if (!rst_n || flush || (!stall && !id_valid)) begin
      valid_q     <= 1'b0;
      alu_q       <= ALU_AND;
      srcA_q      <= 32'd0;
      srcB_q      <= 32'd0;
      store_q     <= 32'd0;
      dest_q      <= 5'd0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (!stall) begin
      valid_q     <= 1'b1;
      alu_q       <= alu_d;
      srcA_q      <= id_rs_data;
      srcB_q      <= srcB_d;
      store_q     <= id_rt_data;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      branch_q    <= branch_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_alu_control = alu_q;
  assign ex_srcA        = srcA_q;
  assign ex_srcB        = srcB_q;
  assign ex_store_data  = store_q;
  assign ex_dest        = dest_q;
  assign ex_reg_write   = reg_write_q;
  assign ex_mem_read    = mem_read_q;
  assign ex_mem_write   = mem_write_q;
  assign ex_branch      = branch_q;
  assign ex_illegal     = illegal_q;

endmodule
`default_nettype wire
